mem_access: RTL and testbench

Memory-access stage that consumes the execute stage's registered outputs: `rz` (ALU result, used as the effective address) and `rm` (store data). It drives a valid/ready data-memory port for loads and stores, and aligns, sign- or zero-extends load data. It produces the write-back value `ry` with a one-cycle `ry_valid` pulse. While a memory transaction is outstanding it asserts `stall` to freeze the upstream pipeline.

---
 rtl/mem_access.sv | 196 +++++++++++++++++++
 tb/tb_mem_access.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// Memory-access pipeline stage: issues loads/stores on a valid/ready data port,
// aligns and extends load data, and produces a one-cycle write-back pulse.
module mem_access #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        mem_en,
  input  logic [3:0]  mem_op,
  input  logic [31:0] rz,
  input  logic [31:0] rm,
  output logic        stall,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_wstrb,
  input  logic        dm_ready,
  input  logic [31:0] dm_rdata,
  input  logic        dm_rvalid,
  output logic [31:0] ry,
  output logic        ry_valid,
  output logic        misalign,
  output logic        bus_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, RDATA} state_t;

  state_t      state_reg, state_next;
  logic        dm_req_reg, dm_req_next;
  logic        dm_we_reg, dm_we_next;
  logic [31:0] dm_addr_reg, dm_addr_next;
  logic [31:0] dm_wdata_reg, dm_wdata_next;
  logic [3:0]  dm_wstrb_reg, dm_wstrb_next;
  logic [31:0] ry_reg, ry_next;
  logic        ry_valid_reg, ry_valid_next;
  logic        misalign_reg, misalign_next;
  logic        bus_err_reg, bus_err_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [3:0]  op_reg, op_next;
  logic [1:0]  lane_reg, lane_next;

  logic        is_misaligned;
  logic        timeout_hit;
  logic [31:0] rdata_shifted;
  logic [31:0] load_result;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      dm_req_reg   <= 1'b0;
      dm_we_reg    <= 1'b0;
      dm_addr_reg  <= '0;
      dm_wdata_reg <= '0;
      dm_wstrb_reg <= '0;
      ry_reg       <= '0;
      ry_valid_reg <= 1'b0;
      misalign_reg <= 1'b0;
      bus_err_reg  <= 1'b0;
      cnt_reg      <= '0;
      op_reg       <= '0;
      lane_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      dm_req_reg   <= dm_req_next;
      dm_we_reg    <= dm_we_next;
      dm_addr_reg  <= dm_addr_next;
      dm_wdata_reg <= dm_wdata_next;
      dm_wstrb_reg <= dm_wstrb_next;
      ry_reg       <= ry_next;
      ry_valid_reg <= ry_valid_next;
      misalign_reg <= misalign_next;
      bus_err_reg  <= bus_err_next;
      cnt_reg      <= cnt_next;
      op_reg       <= op_next;
      lane_reg     <= lane_next;
    end
  end

  always_comb begin
    is_misaligned = (mem_op[1:0] == 2'b11) ||
                    (mem_op[1:0] == 2'b01 && rz[0]) ||
                    (mem_op[1:0] == 2'b10 && rz[1:0] != 2'b00);
    timeout_hit   = (cnt_reg == CW'(TIMEOUT - 1));

    // Lane select uses the offset captured at issue; half lanes are always even.
    rdata_shifted = dm_rdata >> {lane_reg, 3'b000};
    case (op_reg[1:0])
      2'b00:   load_result = op_reg[2] ? {24'b0, rdata_shifted[7:0]}
                                       : {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      2'b01:   load_result = op_reg[2] ? {16'b0, rdata_shifted[15:0]}
                                       : {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      default: load_result = dm_rdata;
    endcase

    state_next    = state_reg;
    dm_req_next   = dm_req_reg;
    dm_we_next    = dm_we_reg;
    dm_addr_next  = dm_addr_reg;
    dm_wdata_next = dm_wdata_reg;
    dm_wstrb_next = dm_wstrb_reg;
    ry_next       = ry_reg;
    ry_valid_next = 1'b0;
    misalign_next = 1'b0;
    bus_err_next  = 1'b0;
    cnt_next      = cnt_reg;
    op_next       = op_reg;
    lane_next     = lane_reg;

    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          if (!mem_en) begin
            ry_next       = rz;
            ry_valid_next = 1'b1;
          end else if (is_misaligned) begin
            ry_next       = '0;
            misalign_next = 1'b1;
            ry_valid_next = 1'b1;
          end else begin
            dm_req_next  = 1'b1;
            dm_we_next   = mem_op[3];
            dm_addr_next = {rz[31:2], 2'b00};
            op_next      = mem_op;
            lane_next    = rz[1:0];
            cnt_next     = '0;
            state_next   = REQ;
            case (mem_op[1:0])
              2'b00: begin
                dm_wdata_next = {4{rm[7:0]}};
                dm_wstrb_next = 4'b0001 << rz[1:0];
              end
              2'b01: begin
                dm_wdata_next = {2{rm[15:0]}};
                dm_wstrb_next = rz[1] ? 4'b1100 : 4'b0011;
              end
              default: begin
                dm_wdata_next = rm;
                dm_wstrb_next = 4'b1111;
              end
            endcase
            if (!mem_op[3]) dm_wstrb_next = 4'b0000;
          end
        end
      end
      REQ: begin
        cnt_next = cnt_reg + CW'(1);
        if (dm_req_reg && dm_ready) begin
          dm_req_next = 1'b0;
          if (op_reg[3]) begin
            ry_next       = {dm_addr_reg[31:2], lane_reg};
            ry_valid_next = 1'b1;
            state_next    = IDLE;
          end else begin
            state_next = RDATA;
          end
        end else if (timeout_hit) begin
          dm_req_next   = 1'b0;
          ry_next       = '0;
          bus_err_next  = 1'b1;
          ry_valid_next = 1'b1;
          state_next    = IDLE;
        end
      end
      RDATA: begin
        cnt_next = cnt_reg + CW'(1);
        if (dm_rvalid) begin
          ry_next       = load_result;
          ry_valid_next = 1'b1;
          state_next    = IDLE;
        end else if (timeout_hit) begin
          ry_next       = '0;
          bus_err_next  = 1'b1;
          ry_valid_next = 1'b1;
          state_next    = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign stall    = (state_reg != IDLE);
  assign dm_req   = dm_req_reg;
  assign dm_we    = dm_we_reg;
  assign dm_addr  = dm_addr_reg;
  assign dm_wdata = dm_wdata_reg;
  assign dm_wstrb = dm_wstrb_reg;
  assign ry       = ry_reg;
  assign ry_valid = ry_valid_reg;
  assign misalign = misalign_reg;
  assign bus_err  = bus_err_reg;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: pass-through, store lanes, load extension,
// misalignment, timeout and mid-transaction reset.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        mem_en;
  logic [3:0]  mem_op;
  logic [31:0] rz;
  logic [31:0] rm;
  logic        stall;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_wstrb;
  logic        dm_ready;
  logic [31:0] dm_rdata;
  logic        dm_rvalid;
  logic [31:0] ry;
  logic        ry_valid;
  logic        misalign;
  logic        bus_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_access #(.TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mem_en(mem_en),
    .mem_op(mem_op), .rz(rz), .rm(rm), .stall(stall), .dm_req(dm_req),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_wstrb(dm_wstrb),
    .dm_ready(dm_ready), .dm_rdata(dm_rdata), .dm_rvalid(dm_rvalid),
    .ry(ry), .ry_valid(ry_valid), .misalign(misalign), .bus_err(bus_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock and sample just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data);
    in_valid = 1'b1; mem_en = 1'b1; mem_op = op; rz = addr; rm = data;
    step();
    in_valid = 1'b0;
  endtask

  // Load with one-cycle handshake; a bogus rvalid during REQ must be ignored.
  task automatic do_load(input string tag, input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] word, input logic [31:0] exp);
    dm_ready = 1'b1;
    issue(op, addr, 32'h0);
    check({tag, "_req"}, {31'b0, dm_req}, 32'h1);
    check({tag, "_wstrb"}, {28'b0, dm_wstrb}, 32'h0);
    dm_rvalid = 1'b1; dm_rdata = 32'hDEAD_BEEF;
    step();
    dm_rvalid = 1'b0;
    check({tag, "_rdata_wait"}, {30'b0, stall, ry_valid}, 32'h2);
    dm_rvalid = 1'b1; dm_rdata = word;
    step();
    dm_rvalid = 1'b0;
    check({tag, "_ry_valid"}, {31'b0, ry_valid}, 32'h1);
    check({tag, "_ry"}, ry, exp);
    check({tag, "_stall"}, {31'b0, stall}, 32'h0);
    $display("load %s addr=0x%08h rdata=0x%08h ry=0x%08h", tag, addr, word, ry);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; in_valid = 1'b0; mem_en = 1'b0; mem_op = 4'h0;
    rz = '0; rm = '0; dm_ready = 1'b0; dm_rdata = '0; dm_rvalid = 1'b0;
    step(); step();
    check("rst_req", {31'b0, dm_req}, 32'h0);
    check("rst_ry", ry, 32'h0);
    check("rst_flags", {28'b0, stall, ry_valid, misalign, bus_err}, 32'h0);
    rst_n = 1'b1;
    step();

    // Pass-through
    in_valid = 1'b1; mem_en = 1'b0; rz = 32'h1234_5678;
    step();
    in_valid = 1'b0;
    check("pass_valid", {31'b0, ry_valid}, 32'h1);
    check("pass_ry", ry, 32'h1234_5678);
    check("pass_req", {30'b0, dm_req, stall}, 32'h0);
    $display("pass rz=0x12345678 ry=0x%08h", ry);
    step();
    check("pass_pulse", {31'b0, ry_valid}, 32'h0);

    // Store byte at lane 2 with three wait cycles
    dm_ready = 1'b0;
    issue(4'b1000, 32'h0000_0102, 32'h0000_00AB);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (stall) n++;
      check("stb_req", {31'b0, dm_req}, 32'h1);
      check("stb_addr", dm_addr, 32'h0000_0100);
      check("stb_wdata", dm_wdata, 32'hABAB_ABAB);
      check("stb_wstrb", {27'b0, dm_we, dm_wstrb}, 32'h14);
      if (i == 3) dm_ready = 1'b1;
      step();
    end
    dm_ready = 1'b0;
    check("stb_stall_cycles", n, 4);
    check("stb_done", {29'b0, ry_valid, stall, dm_req}, 32'h4);
    check("stb_ry", ry, 32'h0000_0102);
    $display("store byte addr=0x%08h strb=0100 ry=0x%08h", dm_addr, ry);
    step();
    check("stb_pulse", {31'b0, ry_valid}, 32'h0);

    // Loads
    do_load("lh_s", 4'b0001, 32'h0000_0202, 32'h8001_0000, 32'hFFFF_8001);
    do_load("lh_u", 4'b0101, 32'h0000_0202, 32'h8001_0000, 32'h0000_8001);
    do_load("lb_s3", 4'b0000, 32'h0000_0303, 32'h8512_3456, 32'hFFFF_FF85);
    do_load("lb_u1", 4'b0100, 32'h0000_0301, 32'h1234_F600, 32'h0000_00F6);
    do_load("lw", 4'b0010, 32'h0000_0400, 32'hCAFE_BABE, 32'hCAFE_BABE);

    // Misaligned word and illegal size
    issue(4'b0010, 32'h0000_0103, 32'h0);
    check("mis_w_flags", {28'b0, ry_valid, misalign, dm_req, stall}, 32'hC);
    check("mis_w_ry", ry, 32'h0);
    $display("misaligned word addr=0x103 misalign=%0b ry=0x%08h", misalign, ry);
    issue(4'b0011, 32'h0000_0100, 32'h0);
    check("mis_sz3_flags", {28'b0, ry_valid, misalign, dm_req, stall}, 32'hC);
    step();
    check("mis_pulse", {30'b0, ry_valid, misalign}, 32'h0);

    // Timeout with dm_ready stuck low
    dm_ready = 1'b0;
    issue(4'b1010, 32'h0000_0500, 32'h1122_3344);
    check("to_wdata", dm_wdata, 32'h1122_3344);
    check("to_wstrb", {28'b0, dm_wstrb}, 32'hF);
    n = 0;
    while (stall && n < 20) begin
      n++;
      step();
    end
    check("to_cycles", n, 8);
    check("to_flags", {27'b0, bus_err, ry_valid, misalign, dm_req, stall}, 32'h18);
    check("to_ry", ry, 32'h0);
    $display("timeout cycles=%0d bus_err=%0b", n, bus_err);
    step();
    check("to_pulse", {31'b0, bus_err}, 32'h0);

    // Reset while waiting in RDATA
    dm_ready = 1'b1;
    issue(4'b0010, 32'h0000_0600, 32'h0);
    step();
    dm_ready = 1'b0;
    check("rr_in_rdata", {30'b0, stall, dm_req}, 32'h2);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("rr_flags", {27'b0, stall, dm_req, ry_valid, misalign, bus_err}, 32'h0);
    check("rr_addr", dm_addr, 32'h0);
    check("rr_ry", ry, 32'h0);
    dm_rvalid = 1'b1; dm_rdata = 32'h5555_5555;
    step();
    dm_rvalid = 1'b0;
    check("rr_late_rvalid", {30'b0, ry_valid, stall}, 32'h0);
    $display("reset in rdata stall=%0b ry_valid=%0b", stall, ry_valid);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
